x_and_reduce_pipe: RTL and testbench
====================================

X_AND_REDUCE_PIPE -- requirements
Module: x_and_reduce_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, number of reduced input bits (legal 1..64).
REQ-002 SHALL have parameter FANIN, default 4, inputs combined per pipeline stage (legal 2..8).
REQ-003 SHALL have parameter LOC, default "UNPLACED", placement attribute with no functional effect.
REQ-004 SHALL have port CLK, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port RSTN, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port CE, input, 1, pipeline advance enable.
REQ-007 SHALL have port I_VALID, input, 1, marks I and MODE as a valid operand.
REQ-008 SHALL have port MODE, input, 2, operation: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-009 SHALL have port I, input, WIDTH, operand bits.
REQ-010 SHALL have port O, output, 1, registered reduction result.
REQ-011 SHALL have port O_VALID, output, 1, high for each cycle O carries a newly completed result.

Function
REQ-012 SHALL use L = ceil(log_FANIN(WIDTH)) register stages, with L = 1 when WIDTH <= FANIN, including WIDTH = 1.
REQ-013 Stage k SHALL split the previous stage vector into groups of FANIN, LSB-aligned, and reduce each group with the stage's mode operator.
REQ-014 Unfilled positions of a partial group SHALL be padded with the identity: 1 for AND/NAND, 0 for OR/XOR.
REQ-015 NAND SHALL be computed as AND through all stages, with inversion applied only at the final stage.
REQ-016 MODE SHALL be captured with I at stage 1 and carried alongside the data, so operands with different modes may be in flight together.
REQ-017 A valid bit SHALL travel with each stage; the stage-1 valid bit loads I_VALID.
REQ-018 When CE=1, every stage SHALL shift its valid bit forward, and its data/mode only if the incoming valid bit is 1.
REQ-019 When CE=0, all stage registers, O and O_VALID SHALL hold; no operand SHALL be lost or duplicated.
REQ-020 Latency SHALL be L CE-enabled cycles from I_VALID sampled high to O_VALID high with O valid.
REQ-021 Throughput SHALL be one operand per CE-enabled cycle; back-to-back I_VALID SHALL produce back-to-back O_VALID.
REQ-022 O SHALL hold the last completed result while O_VALID is low.
REQ-023 Operand values on I or MODE while I_VALID=0 SHALL NOT affect O.

Reset
REQ-024 While RSTN=0, all stage data, mode and valid registers SHALL be 0, with O=0 and O_VALID=0, independent of CLK.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operands; none SHALL appear after release.
REQ-026 The first rising CLK edge with RSTN=1 SHALL sample inputs normally.

Verification
REQ-027 Use WIDTH=8, FANIN=4 (L=2), CE=1, MODE=00: I=FF with a one-cycle I_VALID pulse -> O=1 and O_VALID=1 exactly 2 cycles later; then I=7F -> O=0.
REQ-028 Drive MODE 01/10/11 back-to-back with I=01, 03, FF -> O sequence 1, 0, 0 on consecutive O_VALID cycles.
REQ-029 Apply 4 consecutive valid operands with CE=0 for 3 cycles mid-stream -> all 4 results in order, O/O_VALID frozen during the stall, and no duplicate O_VALID.
REQ-030 Use WIDTH=5, FANIN=4 (padding): AND on I=1F -> 1; XOR on I=10 -> 1; OR on I=00 -> 0.
REQ-031 Assert RSTN=0 asynchronously with 2 operands in flight -> O=0 and O_VALID=0 immediately, and no O_VALID for 3 cycles after release with I_VALID=0.
REQ-032 Use WIDTH=1 -> latency 1 cycle; NAND of I=1 -> O=0.

Source files
------------

// File: rtl/x_and_reduce_pipe.sv
// -----------------------------------------------------------------------------
// x_and_reduce_pipe
//
// Pipelined bitwise reduction (AND / OR / XOR / NAND) of a WIDTH-bit operand.
// Each stage reduces groups of FANIN bits from the previous stage. The tree has
// L = ceil(log_FANIN(WIDTH)) register stages, with a minimum of one stage.
//
// Handshake: valid only, with no backpressure. An operand is accepted on every
// rising CLK edge where CE=1 and I_VALID=1. When CE=0, the whole pipeline holds,
// including O and O_VALID. O_VALID rises L enabled edges after the operand is
// accepted. O keeps the last completed result between valid cycles.
//
// Parameters
//   WIDTH : number of reduced input bits (1..64)
//   FANIN : inputs combined per stage (2..8)
//   LOC   : placement attribute only; it has no functional effect
//
// Ports
//   CLK     : clock; all state changes on its rising edge
//   RSTN    : asynchronous active-low reset; clears every stage
//   CE      : pipeline advance enable
//   I_VALID : qualifies I and MODE
//   MODE    : 00 AND, 01 OR, 10 XOR, 11 NAND
//   I       : operand bits
//   O       : registered reduction result
//   O_VALID : O carries a newly completed result
// -----------------------------------------------------------------------------
module x_and_reduce_pipe #(
    parameter int WIDTH = 8,
    parameter int FANIN = 4,
    parameter     LOC   = "UNPLACED"
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic             I_VALID,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] I,
    output logic             O,
    output logic             O_VALID
);

    // Width of the vector that leaves stage k. Stage 0 is the raw operand.
    function automatic int f_stage_w(input int k);
        int w;
        w = WIDTH;
        for (int s = 0; s < k; s++) begin
            w = (w + FANIN - 1) / FANIN;
        end
        return w;
    endfunction

    // The tree always has at least one stage, even when WIDTH is 1.
    function automatic int f_levels();
        int w;
        int l;
        w = (WIDTH + FANIN - 1) / FANIN;
        l = 1;
        while (w > 1) begin
            w = (w + FANIN - 1) / FANIN;
            l++;
        end
        return l;
    endfunction

    localparam int L = f_levels();

    for (genvar k = 1; k <= L; k++) begin : g_stage
        localparam int IN_W  = f_stage_w(k - 1);
        localparam int OUT_W = f_stage_w(k);

        logic [IN_W-1:0]        w_in;
        logic [1:0]             w_mode_in;
        logic                   w_vld_in;
        logic                   w_id;
        logic [OUT_W*FANIN-1:0] w_pad;
        logic [OUT_W-1:0]       w_red;
        logic [OUT_W-1:0]       w_next;

        logic [OUT_W-1:0]       r_data;
        logic [1:0]             r_mode;
        logic                   r_vld;

        if (k == 1) begin : g_src
            assign w_in      = I;
            assign w_mode_in = MODE;
            assign w_vld_in  = I_VALID;
        end else begin : g_src
            assign w_in      = g_stage[k-1].r_data;
            assign w_mode_in = g_stage[k-1].r_mode;
            assign w_vld_in  = g_stage[k-1].r_vld;
        end

        // The identity is 1 for AND/NAND (00, 11) and 0 for OR/XOR (01, 10).
        assign w_id = ~(w_mode_in[1] ^ w_mode_in[0]);

        always_comb begin : p_reduce
            logic v_acc;
            v_acc = 1'b0;
            w_red = '0;
            // Fill the short top group with the identity so it leaves the result unchanged.
            w_pad = {(OUT_W*FANIN){w_id}};
            w_pad[IN_W-1:0] = w_in;
            for (int g = 0; g < OUT_W; g++) begin
                v_acc = w_id;
                for (int j = 0; j < FANIN; j++) begin
                    case (w_mode_in)
                        2'b01:   v_acc = v_acc | w_pad[g*FANIN+j];
                        2'b10:   v_acc = v_acc ^ w_pad[g*FANIN+j];
                        default: v_acc = v_acc & w_pad[g*FANIN+j];
                    endcase
                end
                w_red[g] = v_acc;
            end
        end

        // NAND stays as AND through the tree. The last stage applies the inversion.
        if (k == L) begin : g_final
            assign w_next = (w_mode_in == 2'b11) ? ~w_red : w_red;
        end else begin : g_mid
            assign w_next = w_red;
        end

        // The valid bit always advances. Data and mode load only for a real
        // operand, so the output keeps the last result through idle cycles.
        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                r_data <= '0;
                r_mode <= 2'b00;
                r_vld  <= 1'b0;
            end else if (CE) begin
                r_vld <= w_vld_in;
                if (w_vld_in) begin
                    r_data <= w_next;
                    r_mode <= w_mode_in;
                end
            end
        end
    end

    assign O       = g_stage[L].r_data[0];
    assign O_VALID = g_stage[L].r_vld;

endmodule

// File: tb/tb_x_and_reduce_pipe.sv
module tb_x_and_reduce_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // main instance: WIDTH=8 FANIN=4 (L=2)
  logic       m_ce = 1'b1;
  logic       m_i_valid = 1'b0;
  logic [1:0] m_mode = 2'b00;
  logic [7:0] m_i = 8'h00;
  logic       m_o, m_o_valid;

  // padding instance: WIDTH=5 FANIN=4 (L=2)
  logic       p_i_valid = 1'b0;
  logic [1:0] p_mode = 2'b00;
  logic [4:0] p_i = 5'h00;
  logic       p_o, p_o_valid;

  // single-bit instance: WIDTH=1 (L=1)
  logic       s_i_valid = 1'b0;
  logic [1:0] s_mode = 2'b00;
  logic [0:0] s_i = 1'b0;
  logic       s_o, s_o_valid;

  x_and_reduce_pipe #(.WIDTH(8), .FANIN(4), .LOC("X0Y0")) u_main (
    .CLK(clk), .RSTN(rstn), .CE(m_ce), .I_VALID(m_i_valid), .MODE(m_mode),
    .I(m_i), .O(m_o), .O_VALID(m_o_valid));

  x_and_reduce_pipe #(.WIDTH(5), .FANIN(4)) u_pad (
    .CLK(clk), .RSTN(rstn), .CE(1'b1), .I_VALID(p_i_valid), .MODE(p_mode),
    .I(p_i), .O(p_o), .O_VALID(p_o_valid));

  x_and_reduce_pipe #(.WIDTH(1), .FANIN(4)) u_one (
    .CLK(clk), .RSTN(rstn), .CE(1'b1), .I_VALID(s_i_valid), .MODE(s_mode),
    .I(s_i), .O(s_o), .O_VALID(s_o_valid));

  // ---------------- enabled-edge counters ----------------
  int   m_en = 0;
  int   cyc = 0;
  logic m_last_ce = 1'b0;
  always @(posedge clk) begin
    m_en      <= m_en + (m_ce ? 1 : 0);
    m_last_ce <= m_ce;
    cyc       <= cyc + 1;
  end

  // ---------------- scoreboard state ----------------
  logic [0:0] m_exp_q[$];
  int         m_due_q[$];
  logic [0:0] p_exp_q[$];
  int         p_due_q[$];
  logic [0:0] s_exp_q[$];
  int         s_due_q[$];
  logic       m_last = 1'b0;
  logic       p_last = 1'b0;
  logic       s_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rstn) begin
      // While stalled, O_VALID holds high without carrying a new result.
      if (m_o_valid && m_last_ce) begin
        if (m_exp_q.size() == 0) begin
          chk("main_unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [0:0] e;
          int d;
          e = m_exp_q.pop_front();
          d = m_due_q.pop_front();
          chk("main_o", {31'd0, m_o}, {31'd0, e});
          chk("main_latency", m_en, d);
          m_last = e;
        end
      end else if (!m_o_valid) begin
        chk("main_hold", {31'd0, m_o}, {31'd0, m_last});
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (p_o_valid) begin
        if (p_exp_q.size() == 0) begin
          chk("pad_unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [0:0] e;
          int d;
          e = p_exp_q.pop_front();
          d = p_due_q.pop_front();
          chk("pad_o", {31'd0, p_o}, {31'd0, e});
          chk("pad_latency", cyc, d);
          p_last = e;
        end
      end else begin
        chk("pad_hold", {31'd0, p_o}, {31'd0, p_last});
      end
    end
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (s_o_valid) begin
        if (s_exp_q.size() == 0) begin
          chk("one_unexpected_valid", 32'd1, 32'd0);
        end else begin
          logic [0:0] e;
          int d;
          e = s_exp_q.pop_front();
          d = s_due_q.pop_front();
          chk("one_o", {31'd0, s_o}, {31'd0, e});
          chk("one_latency", cyc, d);
          s_last = e;
        end
      end else begin
        chk("one_hold", {31'd0, s_o}, {31'd0, s_last});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic m_send(input logic [1:0] md, input logic [7:0] v, input logic e);
    m_i_valid = 1'b1;
    m_mode    = md;
    m_i       = v;
    m_exp_q.push_back(e);
    m_due_q.push_back(m_en + 2);
    @(negedge clk);
    m_i_valid = 1'b0;
    m_mode    = 2'($urandom_range(0, 3));
    m_i       = 8'($urandom_range(0, 255));
  endtask

  task automatic m_idle(input int n);
    repeat (n) begin
      m_i_valid = 1'b0;
      m_mode    = 2'($urandom_range(0, 3));
      m_i       = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
  endtask

  task automatic p_send(input logic [1:0] md, input logic [4:0] v, input logic e);
    p_i_valid = 1'b1;
    p_mode    = md;
    p_i       = v;
    p_exp_q.push_back(e);
    p_due_q.push_back(cyc + 2);
    @(negedge clk);
    p_i_valid = 1'b0;
    p_i       = 5'($urandom_range(0, 31));
  endtask

  task automatic s_send(input logic [1:0] md, input logic v, input logic e);
    s_i_valid = 1'b1;
    s_mode    = md;
    s_i       = v;
    s_exp_q.push_back(e);
    s_due_q.push_back(cyc + 1);
    @(negedge clk);
    s_i_valid = 1'b0;
    s_i       = 1'($urandom_range(0, 1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic snap_o;
    logic snap_v;

    // reset state, checked before any clock edge
    #1;
    chk("rst_main_o", {31'd0, m_o}, 32'd0);
    chk("rst_main_v", {31'd0, m_o_valid}, 32'd0);
    chk("rst_pad_v", {31'd0, p_o_valid}, 32'd0);
    chk("rst_one_v", {31'd0, s_o_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // AND, then a single cleared bit
    m_send(2'b00, 8'hFF, 1'b1);
    m_idle(3);
    m_send(2'b00, 8'h7F, 1'b0);
    m_idle(3);

    // OR / XOR / NAND back to back
    m_send(2'b01, 8'h01, 1'b1);
    m_send(2'b10, 8'h03, 1'b0);
    m_send(2'b11, 8'hFF, 1'b0);
    m_idle(4);

    // four operands, then a 3-cycle stall while they are in flight
    m_send(2'b00, 8'hFF, 1'b1);
    m_send(2'b01, 8'h00, 1'b0);
    m_send(2'b10, 8'h01, 1'b1);
    m_send(2'b11, 8'h0F, 1'b1);
    m_ce   = 1'b0;
    snap_o = m_o;
    snap_v = m_o_valid;
    repeat (3) begin
      @(negedge clk);
      chk("stall_o", {31'd0, m_o}, {31'd0, snap_o});
      chk("stall_v", {31'd0, m_o_valid}, {31'd0, snap_v});
    end
    m_ce = 1'b1;
    m_idle(4);

    // padded partial group
    p_send(2'b00, 5'h1F, 1'b1);
    p_send(2'b10, 5'h10, 1'b1);
    p_send(2'b01, 5'h00, 1'b0);
    p_send(2'b11, 5'h1F, 1'b0);
    repeat (3) @(negedge clk);

    // single-bit tree
    s_send(2'b11, 1'b1, 1'b0);
    s_send(2'b00, 1'b1, 1'b1);
    s_send(2'b10, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // asynchronous reset with two operands in flight
    m_i_valid = 1'b1;
    m_mode    = 2'b00;
    m_i       = 8'hFF;
    @(negedge clk);
    m_mode    = 2'b01;
    m_i       = 8'hFF;
    @(posedge clk);
    #2;
    m_i_valid = 1'b0;
    rstn      = 1'b0;
    #1;
    chk("async_rst_o", {31'd0, m_o}, 32'd0);
    chk("async_rst_v", {31'd0, m_o_valid}, 32'd0);
    m_last = 1'b0;
    p_last = 1'b0;
    s_last = 1'b0;
    @(negedge clk);
    #2;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_no_valid", {31'd0, m_o_valid}, 32'd0);
    end

    // normal operation straight after release
    m_send(2'b00, 8'hFF, 1'b1);
    m_idle(4);

    chk("main_queue_empty", m_exp_q.size(), 32'd0);
    chk("pad_queue_empty", p_exp_q.size(), 32'd0);
    chk("one_queue_empty", s_exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
